// File: rtl/usb_reg_responder_pkg.sv
// Shared definitions for the USB register bus responder: state encodings
// and the address field split between register address and byte index.
package usb_reg_responder_pkg;

    typedef enum logic [2:0] {
        ST_SYNC     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_WR_WAIT  = 3'd2,
        ST_RD_HOLD  = 3'd3,
        ST_ERR_WAIT = 3'd4
    } usb_state_e;

    localparam int USB_ADDR_WIDTH   = 21;
    localparam int USB_BYTECNT_SIZE = 7;
    localparam int USB_TXN_WIDTH    = 16;
    localparam logic [7:0] USB_ERR_MAX = 8'hFF;

endpackage

// File: rtl/usb_reg_responder.sv
// Target-side responder for the SAM3U parallel register bus: turns each
// chip-select cycle into one read or write strobe and counts traffic/errors.
module usb_reg_responder
    import usb_reg_responder_pkg::*;
#(
    parameter int pADDR_WIDTH   = USB_ADDR_WIDTH,
    parameter int pBYTECNT_SIZE = USB_BYTECNT_SIZE,
    parameter int pTXN_WIDTH    = USB_TXN_WIDTH
) (
    input  logic                                 usb_clk,
    input  logic                                 rst,
    input  logic [pADDR_WIDTH-1:0]               usb_addr,
    input  logic [7:0]                           usb_din,
    input  logic                                 usb_rdn,
    input  logic                                 usb_wrn,
    input  logic                                 usb_cen,
    output logic [7:0]                           usb_dout,
    output logic                                 usb_isout,
    output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    output logic [7:0]                           reg_datao,
    input  logic [7:0]                           reg_datai,
    output logic                                 reg_write,
    output logic                                 reg_read,
    output logic                                 reg_addrvalid,
    output logic [pTXN_WIDTH-1:0]                txn_count,
    output logic [7:0]                           err_count
);

    localparam int RA_W = pADDR_WIDTH - pBYTECNT_SIZE;

    usb_state_e                 state_q, state_d;
    logic [RA_W-1:0]            addr_q, addr_d;
    logic [pBYTECNT_SIZE-1:0]   bcnt_q, bcnt_d;
    logic [7:0]                 datao_q, datao_d;
    logic [7:0]                 dout_q, dout_d;
    logic                       isout_q, isout_d;
    logic                       wr_q, wr_d;
    logic                       rd_q, rd_d;
    logic [pTXN_WIDTH-1:0]      txn_q, txn_d;
    logic [7:0]                 err_q, err_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        bcnt_d  = bcnt_q;
        datao_d = datao_q;
        dout_d  = dout_q;
        isout_d = isout_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        txn_d   = txn_q;
        err_d   = err_q;

        case (state_q)
            // A chip select already low at reset release is not a transaction.
            ST_SYNC: begin
                addr_d = usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
                bcnt_d = usb_addr[pBYTECNT_SIZE-1:0];
                if (usb_cen) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                addr_d = usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
                bcnt_d = usb_addr[pBYTECNT_SIZE-1:0];
                if (!usb_cen) begin
                    if (!usb_wrn && usb_rdn) begin
                        datao_d = usb_din;
                        wr_d    = 1'b1;
                        txn_d   = txn_q + pTXN_WIDTH'(1);
                        state_d = ST_WR_WAIT;
                    end else if (!usb_rdn && usb_wrn) begin
                        // reg_datai is decoded from the address registered last cycle.
                        dout_d  = reg_datai;
                        isout_d = 1'b1;
                        rd_d    = 1'b1;
                        txn_d   = txn_q + pTXN_WIDTH'(1);
                        state_d = ST_RD_HOLD;
                    end else begin
                        if (err_q != USB_ERR_MAX) err_d = err_q + 8'd1;
                        state_d = ST_ERR_WAIT;
                    end
                end
            end
            ST_WR_WAIT, ST_ERR_WAIT: begin
                if (usb_cen) state_d = ST_IDLE;
            end
            ST_RD_HOLD: begin
                if (usb_rdn && usb_cen) begin
                    isout_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge usb_clk) begin
        if (rst) begin
            state_q <= ST_SYNC;
            addr_q  <= '0;
            bcnt_q  <= '0;
            datao_q <= '0;
            dout_q  <= '0;
            isout_q <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            txn_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bcnt_q  <= bcnt_d;
            datao_q <= datao_d;
            dout_q  <= dout_d;
            isout_q <= isout_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            txn_q   <= txn_d;
            err_q   <= err_d;
        end
    end

    assign usb_dout      = dout_q;
    assign usb_isout     = isout_q;
    assign reg_address   = addr_q;
    assign reg_bytecnt   = bcnt_q;
    assign reg_datao     = datao_q;
    assign reg_write     = wr_q;
    assign reg_read      = rd_q;
    assign reg_addrvalid = (state_q == ST_WR_WAIT) || (state_q == ST_RD_HOLD) ||
                           (state_q == ST_ERR_WAIT);
    assign txn_count     = txn_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_usb_reg_responder.sv
// Scoreboard bench for usb_reg_responder; a second instance with an 8-bit
// transaction counter shares the stimulus so the wrap is reachable quickly.
`timescale 1ns/1ps
module tb_usb_reg_responder;

    logic        usb_clk = 1'b0;
    logic        rst;
    logic [20:0] usb_addr;
    logic [7:0]  usb_din;
    logic        usb_rdn, usb_wrn, usb_cen;
    logic [7:0]  usb_dout;
    logic        usb_isout;
    logic [13:0] reg_address;
    logic [6:0]  reg_bytecnt;
    logic [7:0]  reg_datao, reg_datai;
    logic        reg_write, reg_read, reg_addrvalid;
    logic [15:0] txn_count;
    logic [7:0]  err_count;

    logic [7:0]  d2_dout, d2_datao, d2_err;
    logic        d2_isout, d2_wr, d2_rd, d2_av;
    logic [13:0] d2_addr;
    logic [6:0]  d2_bc;
    logic [7:0]  d2_txn;

    always #5 usb_clk = ~usb_clk;

    usb_reg_responder dut (
        .usb_clk(usb_clk), .rst(rst), .usb_addr(usb_addr), .usb_din(usb_din),
        .usb_rdn(usb_rdn), .usb_wrn(usb_wrn), .usb_cen(usb_cen),
        .usb_dout(usb_dout), .usb_isout(usb_isout),
        .reg_address(reg_address), .reg_bytecnt(reg_bytecnt),
        .reg_datao(reg_datao), .reg_datai(reg_datai),
        .reg_write(reg_write), .reg_read(reg_read), .reg_addrvalid(reg_addrvalid),
        .txn_count(txn_count), .err_count(err_count)
    );

    usb_reg_responder #(.pTXN_WIDTH(8)) dut8 (
        .usb_clk(usb_clk), .rst(rst), .usb_addr(usb_addr), .usb_din(usb_din),
        .usb_rdn(usb_rdn), .usb_wrn(usb_wrn), .usb_cen(usb_cen),
        .usb_dout(d2_dout), .usb_isout(d2_isout),
        .reg_address(d2_addr), .reg_bytecnt(d2_bc),
        .reg_datao(d2_datao), .reg_datai(reg_datai),
        .reg_write(d2_wr), .reg_read(d2_rd), .reg_addrvalid(d2_av),
        .txn_count(d2_txn), .err_count(d2_err)
    );

    // Register-block read data model, combinational on the decoded address.
    function automatic logic [7:0] rd_model(input logic [13:0] a, input logic [6:0] b);
        if (a == 14'h25 && b == 7'd1) return 8'h3C;
        return a[7:0] ^ {b, 1'b0};
    endfunction
    assign reg_datai = rd_model(reg_address, reg_bytecnt);

    typedef struct {
        bit          is_rd;
        logic [13:0] addr;
        logic [6:0]  bc;
        logic [7:0]  data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_wr = 0;
    int   n_rd = 0;
    int   exp_txn = 0;
    int   exp_err = 0;
    bit   prev_wr = 0;
    bit   prev_rd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge usb_clk) begin
        exp_t e;
        if (rst) begin
            prev_wr = 0;
            prev_rd = 0;
        end else begin
            if (reg_write || reg_read) begin
                chk("wr_rd_excl", {31'd0, reg_write && reg_read}, 0);
                chk("strobe_consec", {31'd0, (reg_write && prev_wr) || (reg_read && prev_rd)}, 0);
                chk("sb_nonempty", {31'd0, sb.size() > 0}, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("kind", {31'd0, reg_read}, {31'd0, e.is_rd});
                    chk("reg_address", {18'd0, reg_address}, {18'd0, e.addr});
                    chk("reg_bytecnt", {25'd0, reg_bytecnt}, {25'd0, e.bc});
                    if (e.is_rd) begin
                        chk("rd_dout", {24'd0, usb_dout}, {24'd0, e.data});
                        chk("rd_isout", {31'd0, usb_isout}, 1);
                    end else begin
                        chk("wr_datao", {24'd0, reg_datao}, {24'd0, e.data});
                    end
                    chk("addrvalid", {31'd0, reg_addrvalid}, 1);
                end
                if (reg_write) n_wr++;
                if (reg_read)  n_rd++;
            end
            prev_wr = reg_write;
            prev_rd = reg_read;
        end
    end

    task automatic setup_addr(input logic [20:0] a);
        usb_addr = a;
        usb_cen  = 1'b1;
        usb_rdn  = 1'b1;
        usb_wrn  = 1'b1;
        tick();
        tick();
    endtask

    task automatic do_write(input logic [20:0] a, input logic [7:0] d, input int hold);
        exp_t e;
        e.is_rd = 0; e.addr = a[20:7]; e.bc = a[6:0]; e.data = d;
        setup_addr(a);
        sb.push_back(e);
        usb_cen = 1'b0; usb_wrn = 1'b0; usb_din = d;
        tick();
        exp_txn++;
        repeat (hold - 1) tick();
        usb_cen = 1'b1; usb_wrn = 1'b1; usb_din = 8'h00;
        tick();
    endtask

    task automatic do_read(input logic [20:0] a, input int hold, input string tag);
        exp_t e;
        e.is_rd = 1; e.addr = a[20:7]; e.bc = a[6:0]; e.data = rd_model(a[20:7], a[6:0]);
        setup_addr(a);
        sb.push_back(e);
        usb_cen = 1'b0; usb_rdn = 1'b0;
        tick();
        exp_txn++;
        chk({tag, "_dout_first"}, {24'd0, usb_dout}, {24'd0, e.data});
        chk({tag, "_isout_first"}, {31'd0, usb_isout}, 1);
        usb_wrn = 1'b0;  // ignored while holding
        repeat (hold - 1) begin
            tick();
            chk({tag, "_isout_hold"}, {31'd0, usb_isout}, 1);
            chk({tag, "_dout_hold"}, {24'd0, usb_dout}, {24'd0, e.data});
        end
        usb_wrn = 1'b1; usb_rdn = 1'b1;
        tick();
        chk({tag, "_isout_rdn_only"}, {31'd0, usb_isout}, 1);
        usb_cen = 1'b1;
        tick();
        chk({tag, "_isout_release"}, {31'd0, usb_isout}, 0);
    endtask

    task automatic do_err();
        setup_addr(21'h00100);
        usb_cen = 1'b0; usb_rdn = 1'b0; usb_wrn = 1'b0;
        tick();
        if (exp_err < 255) exp_err++;
        usb_cen = 1'b1; usb_rdn = 1'b1; usb_wrn = 1'b1;
        tick();
    endtask

    initial begin
        exp_t e;
        int   w0;
        rst = 1'b1; usb_addr = '0; usb_din = '0;
        usb_cen = 1'b0; usb_rdn = 1'b1; usb_wrn = 1'b0;
        tick(); tick();
        chk("rst_isout", {31'd0, usb_isout}, 0);
        chk("rst_dout", {24'd0, usb_dout}, 0);
        chk("rst_strobes", {30'd0, reg_write, reg_read}, 0);
        chk("rst_addrvalid", {31'd0, reg_addrvalid}, 0);
        chk("rst_counts", {8'd0, txn_count, err_count}, 0);

        // Write request pending at reset release must be ignored.
        rst = 1'b0;
        repeat (3) tick();
        chk("sync_no_write", n_wr, 0);
        chk("sync_txn", {16'd0, txn_count}, 0);

        do_write(21'h01202, 8'hA5, 1);
        chk("w1_count", n_wr, 1);
        chk("w1_txn", {16'd0, txn_count}, exp_txn);
        chk("w1_addr", {18'd0, reg_address}, 32'h24);

        do_write(21'h00345, 8'h5A, 5);
        chk("w5_single", n_wr, 2);
        do_write(21'h00346, 8'h11, 1);
        chk("w_after_rise", n_wr, 3);

        do_read(21'h01281, 3, "rd1");
        chk("rd1_count", n_rd, 1);
        do_read(21'h00083, 1, "rd2");
        chk("rd2_count", n_rd, 2);
        chk("rd_txn", {16'd0, txn_count}, exp_txn);

        do_err();
        chk("err_one", {24'd0, err_count}, exp_err);
        chk("err_no_strobe", n_wr + n_rd, 5);
        for (int i = 0; i < 300; i++) do_err();
        chk("err_sat", {24'd0, err_count}, 32'hFF);
        chk("err_txn", {16'd0, txn_count}, exp_txn);

        // Reset while holding a read.
        setup_addr(21'h00200);
        e.is_rd = 1; e.addr = 14'h4; e.bc = 7'd0; e.data = rd_model(14'h4, 7'd0);
        sb.push_back(e);
        usb_cen = 1'b0; usb_rdn = 1'b0;
        tick(); tick();
        chk("pre_rst_isout", {31'd0, usb_isout}, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_isout", {31'd0, usb_isout}, 0);
        chk("mid_rst_dout", {24'd0, usb_dout}, 0);
        chk("mid_rst_regs", {reg_address, reg_bytecnt, reg_datao, reg_addrvalid, reg_write, reg_read}, 0);
        chk("mid_rst_counts", {8'd0, txn_count, err_count}, 0);
        exp_txn = 0; exp_err = 0;
        rst = 1'b0;
        repeat (3) tick();
        chk("post_rst_no_read", n_rd, 3);
        usb_cen = 1'b1; usb_rdn = 1'b1;
        tick();
        do_read(21'h00181, 2, "rd3");
        chk("rd3_count", n_rd, 4);

        w0 = n_wr;
        for (int i = 0; i < 260; i++) do_write(21'(i * 3), 8'(i), 1);
        chk("bulk_writes", n_wr - w0, 260);
        chk("txn16", {16'd0, txn_count}, exp_txn);
        chk("txn8_wrap", {24'd0, d2_txn}, exp_txn % 256);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/usb_reg_responder.md
# usb_reg_responder

Target-side responder for the parallel USB register bus (USB_Addr / USB_Data / USB_nRD / USB_nWE / USB_nCS) driven by the SAM3U host. The block sits in the top level between the external bus pins and the register blocks (main, trace).

- Decodes each chip-select cycle into a single write or read strobe with a stable address.
- Returns read data on the bus for as long as the host holds nRD low.
- Counts completed transactions and protocol errors.

## Interface
Parameters:
- pADDR_WIDTH, 21, USB address width.
- pBYTECNT_SIZE, 7, low address bits used as the byte index within a register.

Ports:
- usb_clk  in  1  bus clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- usb_addr  in  pADDR_WIDTH  host address.
- usb_din  in  8  host write data (the bus input path).
- usb_rdn  in  1  read enable, active low.
- usb_wrn  in  1  write enable, active low.
- usb_cen  in  1  chip select, active low.
- usb_dout  out  8  read data to the pad.
- usb_isout  out  1  pad output enable; the top level drives the tri-state from it.
- reg_address  out  pADDR_WIDTH-pBYTECNT_SIZE  register address, i.e. usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE].
- reg_bytecnt  out  pBYTECNT_SIZE  byte index, i.e. usb_addr[pBYTECNT_SIZE-1:0].
- reg_datao  out  8  captured write data.
- reg_datai  in  8  read data from the register blocks; combinational on reg_address/reg_bytecnt.
- reg_write  out  1  one-cycle write strobe.
- reg_read  out  1  one-cycle read strobe, used for side effects such as a FIFO pop.
- reg_addrvalid  out  1  high while a transaction is active.
- txn_count  out  16  completed reads plus writes; wraps.
- err_count  out  8  protocol errors; saturates at 0xFF.

## Operation
State machine states: SYNC, IDLE, WR_WAIT, RD_HOLD, ERR_WAIT.
- SYNC: the reset state. Moves to IDLE on the first cycle with usb_cen=1. A chip select already low at reset release is ignored.
- IDLE:
  - reg_address and reg_bytecnt are registered from usb_addr every cycle.
  - On a cycle where usb_cen=0, the sampled usb_wrn and usb_rdn select the action:
  - wrn=0, rdn=1: register reg_datao<=usb_din, pulse reg_write, increment txn_count, go to WR_WAIT.
  - rdn=0, wrn=1: register usb_dout<=reg_datai, set usb_isout=1, pulse reg_read, increment txn_count, go to RD_HOLD.
  - both low or both high: no strobe, increment err_count (saturating), go to ERR_WAIT.
- WR_WAIT: go to IDLE when usb_cen=1.
- RD_HOLD: usb_dout stays frozen and usb_isout stays 1. Go to IDLE, clearing usb_isout, when usb_rdn=1 and usb_cen=1 are sampled together.
- ERR_WAIT: go to IDLE when usb_cen=1.
- In every state other than IDLE and SYNC, reg_address and reg_bytecnt are frozen and reg_addrvalid=1.
- Chip select held low for several cycles produces exactly one strobe. A new transaction starts only after usb_cen has been sampled high.
- usb_wrn or usb_rdn toggling while in WR_WAIT, RD_HOLD or ERR_WAIT is ignored.

## Timing
- Reset values: every output is 0, the state is SYNC, and both counters are 0.
- Address setup: the host presents the address at least one cycle before usb_cen falls. reg_address is registered one cycle after the address appears, so reg_datai has settled by the sampling edge.
- Write: at the edge that samples usb_cen=0, reg_datao is loaded and reg_write is asserted for the following cycle. Write latency is 1 cycle.
- Read: usb_dout is valid immediately after the edge that samples usb_cen=0. The host samples it after that edge. reg_read is high for the same following cycle.
- reg_read and reg_write are never high in the same cycle, and each is never high for two consecutive cycles.
- Reset asserted mid-transaction: outputs clear on the next edge, usb_isout drops immediately, and the state is SYNC.
- txn_count wraps from 0xFFFF to 0. err_count holds at 0xFF.

## Structure
- Shared package (existing defines file) gets the state encodings (3-bit: SYNC=0, IDLE=1, WR_WAIT=2, RD_HOLD=3, ERR_WAIT=4) and the field split constants.
- No sub-module: the FSM, address and data registers, and counters form a single module.
- The tri-state buffer stays in the top level.

## Test plan
- Write 0xA5 at usb_addr=0x1202 (block 1, reg 4, byte 2) -> exactly one reg_write pulse, with reg_address=0x24, reg_bytecnt=2, reg_datao=0xA5, and txn_count=1.
- Read at 0x1281 with reg_datai=0x3C for that address -> usb_dout=0x3C and usb_isout=1 right after the usb_cen=0 sampling edge. usb_isout stays 1 while usb_rdn=0 and drops after usb_rdn=1. Exactly one reg_read pulse.
- usb_cen held low for 5 cycles during a write -> a single reg_write pulse. A second write issued after usb_cen rises is accepted.
- usb_cen=0 with usb_rdn=0 and usb_wrn=0 -> no strobes and err_count=1. After 300 such cycles, err_count=0xFF.
- rst pulsed while in RD_HOLD -> usb_isout=0 and all outputs 0 on the next edge. With usb_cen held low after reset, no strobe occurs until usb_cen has gone high.
- 65536 writes -> txn_count=0.
